// File: rtl/nfa_report_pkg.sv
// Purpose: shared constants and helpers for the NFA match reporter.
// Latency: n/a (package only).
// Backpressure: n/a.
// Report record layout, LSB first: offset [OFF_W], engine id [ID_W], and,
// when REPORT_FLOWID_EN is defined, flow id [FLOW_W].
package nfa_report_pkg;

  localparam int DEF_N_ENG = 8;
  localparam int DEF_ID_W  = 3;
  localparam int DEF_OFF_W = 16;
  localparam int DEF_DEPTH = 4;

  localparam int FLOW_W      = 8;
  localparam int REC_OFF_LSB = 0;

  function automatic int rec_id_lsb(input int off_w);
    return off_w;
  endfunction

  function automatic int rec_flow_lsb(input int id_w, input int off_w);
    return id_w + off_w;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/match_report_fifo.sv
// Purpose: DEPTH-entry synchronous FIFO holding match reports.
// Latency: a push is visible at the head one cycle later; no bypass.
// Backpressure: push is accepted while not full, or while full with a pop in the same cycle.
// Ports: clk, rst (async active-low), push/push_dat, pop, full, empty, head_dat.
// The head is read from the storage registers, so it is stable until popped.
module match_report_fifo
  import nfa_report_pkg::*;
#(
  parameter int W     = DEF_ID_W + DEF_OFF_W,
  parameter int DEPTH = DEF_DEPTH
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_dat
);

  localparam int AW = clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/nfa_match_reporter.sv
// Purpose: detect first match per flow on each engine, timestamp it, queue {id, offset} reports.
// Latency: match_in rise -> pend at next edge -> FIFO write one edge later -> report_valid.
// Backpressure: FIFO full stalls pend (no loss); sod with pend outstanding sets sticky drop.
// Ports: clk, rst (async active-low), sod, en, match_in[N_ENG], report_valid/ready/id/offset,
//        pending, drop; report_flow[7:0] only when REPORT_FLOWID_EN is defined.
// Optional macro REPORT_FLOWID_EN adds a per-sod flow counter stored with each report.
module nfa_match_reporter
  import nfa_report_pkg::*;
#(
  parameter int N_ENG = DEF_N_ENG,
  parameter int ID_W  = DEF_ID_W,
  parameter int OFF_W = DEF_OFF_W,
  parameter int DEPTH = DEF_DEPTH
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             sod,
  input  logic             en,
  input  logic [N_ENG-1:0] match_in,
  output logic             report_valid,
  input  logic             report_ready,
  output logic [ID_W-1:0]  report_id,
  output logic [OFF_W-1:0] report_offset,
  output logic             pending,
  output logic             drop
`ifdef REPORT_FLOWID_EN
  , output logic [FLOW_W-1:0] report_flow
`endif
);

  localparam int ID_LSB = rec_id_lsb(OFF_W);
`ifdef REPORT_FLOWID_EN
  localparam int REC_W = ID_W + OFF_W + FLOW_W;
`else
  localparam int REC_W = ID_W + OFF_W;
`endif

  logic [OFF_W-1:0] byte_cnt;
  logic [N_ENG-1:0] seen, pend, det, clr;
  logic [OFF_W-1:0] off_q [N_ENG];
  logic [ID_W-1:0]  sel_id;
  logic             sel_vld, push, pop, fifo_full, fifo_empty;
  logic [REC_W-1:0] push_dat, head_dat;

  // A match seen in the sod cycle belongs to the old flow's engine state and is ignored.
  assign det  = match_in & ~seen & {N_ENG{~sod}};
  assign pop  = report_valid & report_ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still take the push.
  assign push = sel_vld & (~fifo_full | pop);

  // Lowest-index pending engine wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    sel_id  = '0;
    sel_vld = 1'b0;
    for (int i = N_ENG - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_id  = ID_W'(i);
        sel_vld = 1'b1;
      end
    end
  end

  assign clr = push ? (N_ENG'(1) << sel_id) : '0;

`ifdef REPORT_FLOWID_EN
  logic [FLOW_W-1:0] flow_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     flow_id <= '0;
    else if (sod) flow_id <= flow_id + 1'b1;
  end

  // Captured at push time: a push in the sod cycle still carries the old flow id.
  assign push_dat    = {flow_id, sel_id, off_q[sel_id]};
  assign report_flow = head_dat[rec_flow_lsb(ID_W, OFF_W) +: FLOW_W];
`else
  assign push_dat = {sel_id, off_q[sel_id]};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
      seen     <= '0;
      pend     <= '0;
      drop     <= 1'b0;
      for (int i = 0; i < N_ENG; i++) off_q[i] <= '0;
    end else begin
      // byte_cnt counts bytes already seen, so the matching byte is byte_cnt-1.
      for (int i = 0; i < N_ENG; i++) begin
        if (det[i]) off_q[i] <= byte_cnt - OFF_W'(1);
      end
      if (sod) begin
        byte_cnt <= '0;
        seen     <= '0;
        pend     <= '0;
        if (|pend) drop <= 1'b1;
      end else begin
        if (en) byte_cnt <= byte_cnt + OFF_W'(1);
        seen <= seen | det;
        pend <= (pend & ~clr) | det;
      end
    end
  end

  match_report_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head_dat)
  );

  assign report_valid  = ~fifo_empty;
  assign report_id     = head_dat[ID_LSB +: ID_W];
  assign report_offset = head_dat[REC_OFF_LSB +: OFF_W];
  assign pending       = |pend;

endmodule
